reg_port_sequencer: RTL and testbench
=====================================

Name: reg_port_sequencer

Overview:
- Initiator for the single-port 8-bit register file. It drives the file's one address port, its write enable and its write data, and it reads the file's combinational read data.
- Per request it does three things in sequence: reads two source operands, presents them to an external execute unit, and writes the returned result back to a destination register.
- It sits between the control/decode logic and the register file. It turns one three-register operation into a fixed sequence of single-port accesses.

Parameters:
- W, 8, data path width (matches the register file).
- D, 4, register pointer width (2**D registers).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_ra  in  D  source A register pointer.
- req_rb  in  D  source B register pointer.
- req_rd  in  D  destination register pointer.
- req_wb  in  1  1 = write the result back; 0 = discard the result.
- rf_addr  out  D  register file address.
- rf_write_en  out  1  register file write enable.
- rf_data_in  out  W  register file write data.
- rf_data_out  in  W  register file combinational read data.
- op_a  out  W  latched operand A.
- op_b  out  W  latched operand B.
- op_valid  out  1  operands valid, result awaited.
- res_valid  in  1  result present from the execute unit.
- res_data  in  W  result value.
- done  out  1  one-cycle pulse when the operation retires.

Behaviour:
- Reset (synchronous, Reset=1 at posedge):
  - state returns to IDLE.
  - op_a, op_b, the latched pointers, the latched req_wb and the result register clear to 0.
  - rf_write_en=0, op_valid=0, done=0.
  - Reset mid-operation abandons the operation. No write occurs in the cycle after reset.
- States: IDLE, RD_A, RD_B, WAIT_RES, WB.
- IDLE:
  - req_ready=1, rf_addr=0, rf_write_en=0.
  - On accept: latch ra, rb, rd and wb, then go to RD_A.
- RD_A:
  - rf_addr=ra_q.
  - At the posedge, op_a <= rf_data_out; go to RD_B.
- RD_B:
  - rf_addr=rb_q.
  - At the posedge, op_b <= rf_data_out; go to WAIT_RES.
- WAIT_RES:
  - op_valid=1, rf_addr=rd_q, rf_write_en=0.
  - Stays in this state indefinitely until res_valid=1.
  - On res_valid: res_q <= res_data; go to WB.
  - res_valid in any other state is ignored.
- WB:
  - rf_addr=rd_q, rf_data_in=res_q, rf_write_en=wb_q, done=1.
  - Go to IDLE unconditionally.
- rf_data_in equals res_q in every state. It is only meaningful in WB.
- Latency: accept at cycle 0 → RD_A at 1, RD_B at 2, WAIT_RES from 3.
  - If res_valid arrives in cycle 3, WB (write plus done) is cycle 4.
  - The next request can be accepted at cycle 5 at the earliest.
- Outputs rf_addr, rf_write_en, op_valid, done and req_ready are decoded purely from state (Moore).
- Address 0 is an ordinary register. Reads and writes to pointer 0 are not blanked.
- ra==rb is legal: both reads return the same value.
- rd==ra or rd==rb is legal: the write happens after both reads, so the operands hold the old value.
- req_valid while busy is not accepted (req_ready=0). The requester must hold its request until it is accepted.
- op_a and op_b hold their values after WB until the next RD_A / RD_B capture.

Decomposition:
- Shared package rf_pkg holds:
  - the state enum type rps_state_t {IDLE, RD_A, RD_B, WAIT_RES, WB};
  - the constants RF_W=8 and RF_D=4, which feed both this block and reg_file.
- No sub-module inside the block. The FSM and the capture registers live in one module.
- The bench instantiates reg_file as a sibling and wires rf_* to its CLK, write_en, addr, data_in and data_out.

Test Plan:
- Reset, then preload r3=0x12 and r5=0x34. Request ra=3, rb=5, rd=7, wb=1; the execute model returns op_a+op_b in the cycle op_valid rises.
  - Required: op_a=0x12 and op_b=0x34 by cycle 3; done in cycle 4; r7=0x46 afterwards.
- Same operands with wb=0 and result 0xFF.
  - Required: done pulses; rf_write_en stays 0 in all cycles; r7 is unchanged.
- Hazard case: rd=ra=2 with r2=0x05 and result = op_a+1.
  - Required: op_a=0x05 and r2=0x06 afterwards.
- Pointer 0: ra=0, rb=0, rd=0, r0=0x80, result 0x81.
  - Required: op_a=op_b=0x80 and r0=0x81.
- Hold res_valid low for 10 cycles after op_valid.
  - Required: op_valid stays high; rf_write_en=0 and req_ready=0 throughout; WB follows res_valid by exactly 1 cycle.
  - A req_valid pulse raised during the stall is not accepted.
- Assert Reset in WAIT_RES.
  - Required: the next cycle is IDLE with req_ready=1, op_valid=0 and op_a=op_b=0; the rd register is unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared types and sizing for the register file and its sequencer.
// Revision : 1.0
// ============================================================================
package rf_pkg;

  localparam int RF_W = 8;
  localparam int RF_D = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_A     = 3'd1,
    RD_B     = 3'd2,
    WAIT_RES = 3'd3,
    WB       = 3'd4
  } rps_state_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : Single-port register file, synchronous write, combinational read.
// Revision : 1.0
// ============================================================================
module reg_file
  import rf_pkg::*;
#(
  parameter int W = RF_W,
  parameter int D = RF_D
) (
  input  logic         CLK,
  input  logic         write_en,
  input  logic [D-1:0] addr,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  logic [W-1:0] r_mem [0:(1<<D)-1];

  always_ff @(posedge CLK) begin
    if (write_en) begin
      r_mem[addr] <= data_in;
    end
  end

  assign data_out = r_mem[addr];

endmodule : reg_file
`default_nettype wire

// File: rtl/reg_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_port_sequencer
// Purpose  : Serialises a two-read / one-write register operation onto a
//            single-port register file around an external execute unit.
// Revision : 1.0
// ============================================================================
module reg_port_sequencer
  import rf_pkg::*;
#(
  parameter int W = RF_W,
  parameter int D = RF_D
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [D-1:0] req_ra,
  input  logic [D-1:0] req_rb,
  input  logic [D-1:0] req_rd,
  input  logic         req_wb,
  output logic [D-1:0] rf_addr,
  output logic         rf_write_en,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_valid,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  output logic         done
);

  rps_state_t   r_state;
  rps_state_t   w_next;
  logic [D-1:0] r_ra;
  logic [D-1:0] r_rb;
  logic [D-1:0] r_rd;
  logic         r_wb;
  logic [W-1:0] r_op_a;
  logic [W-1:0] r_op_b;
  logic [W-1:0] r_res;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rd    <= '0;
      r_wb    <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_ra <= req_ra;
            r_rb <= req_rb;
            r_rd <= req_rd;
            r_wb <= req_wb;
          end
        end
        RD_A:     r_op_a <= rf_data_out;
        RD_B:     r_op_b <= rf_data_out;
        WAIT_RES: begin
          if (res_valid) begin
            r_res <= res_data;
          end
        end
        default: ;
      endcase
    end
  end

  // All port-side controls are pure functions of state.
  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    rf_addr     = '0;
    rf_write_en = 1'b0;
    op_valid    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = RD_A;
      end
      RD_A: begin
        rf_addr = r_ra;
        w_next  = RD_B;
      end
      RD_B: begin
        rf_addr = r_rb;
        w_next  = WAIT_RES;
      end
      WAIT_RES: begin
        rf_addr  = r_rd;
        op_valid = 1'b1;
        if (res_valid) w_next = WB;
      end
      WB: begin
        rf_addr     = r_rd;
        rf_write_en = r_wb;
        done        = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign rf_data_in = r_res;

endmodule : reg_port_sequencer
`default_nettype wire

// File: tb/tb_reg_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_port_sequencer
// Purpose  : Directed bench: sequencer plus sibling register file.
// Revision : 1.0
// ============================================================================
module tb_reg_port_sequencer;
  import rf_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_ra = '0, req_rb = '0, req_rd = '0;
  logic       req_wb = 1'b0;
  logic [3:0] dut_rf_addr;
  logic       dut_rf_we;
  logic [7:0] dut_rf_din;
  logic [7:0] rf_dout;
  logic [7:0] op_a, op_b;
  logic       op_valid;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = '0;
  logic       done;

  // Bench takes over the file port only while the sequencer is idle.
  logic       tb_own = 1'b0;
  logic [3:0] tb_addr = '0;
  logic       tb_we = 1'b0;
  logic [7:0] tb_din = '0;
  logic [3:0] rf_addr_m;
  logic       rf_we_m;
  logic [7:0] rf_din_m;

  assign rf_addr_m = tb_own ? tb_addr : dut_rf_addr;
  assign rf_we_m   = tb_own ? tb_we   : dut_rf_we;
  assign rf_din_m  = tb_own ? tb_din  : dut_rf_din;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  reg_port_sequencer u_dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd), .req_wb(req_wb),
    .rf_addr(dut_rf_addr), .rf_write_en(dut_rf_we), .rf_data_in(dut_rf_din),
    .rf_data_out(rf_dout),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_valid(res_valid), .res_data(res_data), .done(done)
  );

  reg_file u_rf (
    .CLK(CLK), .write_en(rf_we_m), .addr(rf_addr_m),
    .data_in(rf_din_m), .data_out(rf_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rf_wr(input logic [3:0] a, input logic [7:0] d);
    tb_own = 1'b1; tb_addr = a; tb_din = d; tb_we = 1'b1;
    step();
    tb_we = 1'b0; tb_own = 1'b0;
  endtask

  task automatic rf_rd(input logic [3:0] a, output logic [7:0] d);
    tb_own = 1'b1; tb_addr = a;
    #1;
    d = rf_dout;
    tb_own = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic wb, input logic [7:0] res,
                        input int stall, input logic [7:0] ea, input logic [7:0] eb);
    chk({tag, ".ready0"}, req_ready, 1);
    req_valid = 1'b1; req_ra = ra; req_rb = rb; req_rd = rd; req_wb = wb;
    step();
    req_valid = 1'b0;
    chk({tag, ".addrA"}, dut_rf_addr, ra);
    chk({tag, ".weA"}, dut_rf_we, 0);
    chk({tag, ".readyA"}, req_ready, 0);
    step();
    chk({tag, ".addrB"}, dut_rf_addr, rb);
    chk({tag, ".weB"}, dut_rf_we, 0);
    step();
    chk({tag, ".opvalid"}, op_valid, 1);
    chk({tag, ".op_a"}, op_a, ea);
    chk({tag, ".op_b"}, op_b, eb);
    for (int i = 0; i < stall; i++) begin
      req_valid = (i == 3);
      if (i == 3) begin
        req_ra = 4'd11; req_rb = 4'd11; req_rd = 4'd11; req_wb = 1'b1;
      end
      chk({tag, ".stall_opv"}, op_valid, 1);
      chk({tag, ".stall_we"}, dut_rf_we, 0);
      chk({tag, ".stall_rdy"}, req_ready, 0);
      chk({tag, ".stall_done"}, done, 0);
      step();
    end
    req_valid = 1'b0;
    chk({tag, ".opvalid_pre"}, op_valid, 1);
    res_valid = 1'b1; res_data = res;
    step();
    res_valid = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".wbwe"}, dut_rf_we, wb);
    chk({tag, ".wbaddr"}, dut_rf_addr, rd);
    chk({tag, ".wbdata"}, dut_rf_din, res);
    step();
    chk({tag, ".idle_rdy"}, req_ready, 1);
    chk({tag, ".idle_done"}, done, 0);
    chk({tag, ".idle_we"}, dut_rf_we, 0);
    chk({tag, ".hold_a"}, op_a, ea);
  endtask

  logic [7:0] rv;

  initial begin
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    chk("rst.ready", req_ready, 1);
    chk("rst.opv", op_valid, 0);
    chk("rst.done", done, 0);
    chk("rst.we", dut_rf_we, 0);
    chk("rst.addr", dut_rf_addr, 0);
    chk("rst.op_a", op_a, 0);
    chk("rst.op_b", op_b, 0);
    chk("rst.din", dut_rf_din, 0);

    rf_wr(4'd3, 8'h12);
    rf_wr(4'd5, 8'h34);
    run_op("add", 4'd3, 4'd5, 4'd7, 1'b1, 8'h46, 0, 8'h12, 8'h34);
    rf_rd(4'd7, rv); chk("add.r7", rv, 8'h46);

    run_op("nowb", 4'd3, 4'd5, 4'd7, 1'b0, 8'hFF, 0, 8'h12, 8'h34);
    rf_rd(4'd7, rv); chk("nowb.r7", rv, 8'h46);

    rf_wr(4'd2, 8'h05);
    run_op("haz", 4'd2, 4'd3, 4'd2, 1'b1, 8'h06, 0, 8'h05, 8'h12);
    rf_rd(4'd2, rv); chk("haz.r2", rv, 8'h06);

    rf_wr(4'd0, 8'h80);
    run_op("p0", 4'd0, 4'd0, 4'd0, 1'b1, 8'h81, 0, 8'h80, 8'h80);
    rf_rd(4'd0, rv); chk("p0.r0", rv, 8'h81);

    rf_wr(4'd11, 8'h33);
    run_op("stall", 4'd3, 4'd5, 4'd10, 1'b1, 8'h77, 10, 8'h12, 8'h34);
    rf_rd(4'd10, rv); chk("stall.r10", rv, 8'h77);
    rf_rd(4'd11, rv); chk("stall.r11", rv, 8'h33);
    chk("stall.still_idle", req_ready, 1);

    rf_wr(4'd9, 8'h5A);
    req_valid = 1'b1; req_ra = 4'd3; req_rb = 4'd5; req_rd = 4'd9; req_wb = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rstw.opv", op_valid, 1);
    res_data = 8'hEE;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rstw.ready", req_ready, 1);
    chk("rstw.opv0", op_valid, 0);
    chk("rstw.op_a", op_a, 0);
    chk("rstw.op_b", op_b, 0);
    chk("rstw.we", dut_rf_we, 0);
    chk("rstw.done", done, 0);
    step();
    chk("rstw.we2", dut_rf_we, 0);
    rf_rd(4'd9, rv); chk("rstw.r9", rv, 8'h5A);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_reg_port_sequencer
`default_nettype wire
